sd_access_arbiter: RTL and testbench

Round-robin arbiter that shares the single SD-card word-access controller among three clients: score reader/writer, settings store and level loader. Each client issues one 16-bit read or write at a 32-bit address with a level-REQ / pulse-DONE handshake. The arbiter sits between the clients and the SD controller and sequences that controller's strobe/busy protocol. It also guards against a controller that never accepts a command.

---
 rtl/sd_access_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_sd_access_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_access_arbiter.sv
// Round-robin share of the SD word-access controller among three REQ/DONE clients.
// Registered outputs: grant and strobe one edge after REQ; a client waits until it is granted.
module sd_access_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [2:0]  REQ,
    input  logic [2:0]  REQ_WRITE,
    input  logic [95:0] REQ_ADDR,
    input  logic [47:0] REQ_WDATA,
    output logic [2:0]  GRANT,
    output logic [2:0]  DONE,
    output logic        ERR,
    output logic [15:0] RDATA,
    input  logic        SD_HAS_INITIALIZED,
    input  logic        SD_IS_READING,
    input  logic        SD_IS_WRITING,
    input  logic [15:0] SD_READ_DATA,
    output logic        SD_TO_READ,
    output logic        SD_TO_WRITE,
    output logic [31:0] SD_READ_ADDRESS,
    output logic [31:0] SD_WRITE_ADDRESS,
    output logic [15:0] SD_WRITE_DATA
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] rdata_q, rdata_d;
    logic        to_read_q, to_read_d;
    logic        to_write_q, to_write_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        op_wr_q, op_wr_d;
    logic [1:0]  last_q, last_d;
    logic [31:0] cnt_q, cnt_d;

    logic [2:0]  win_oh;
    logic [31:0] sel_addr;
    logic [15:0] sel_wdata;
    logic        sel_wr;
    logic        can_grant;
    logic        busy_sel;

    // Search starts at the client after the one served last.
    always_comb begin
        win_oh = 3'b000;
        case (last_q)
            2'd0: begin
                if (REQ[1])      win_oh = 3'b010;
                else if (REQ[2]) win_oh = 3'b100;
                else if (REQ[0]) win_oh = 3'b001;
            end
            2'd1: begin
                if (REQ[2])      win_oh = 3'b100;
                else if (REQ[0]) win_oh = 3'b001;
                else if (REQ[1]) win_oh = 3'b010;
            end
            default: begin
                if (REQ[0])      win_oh = 3'b001;
                else if (REQ[1]) win_oh = 3'b010;
                else if (REQ[2]) win_oh = 3'b100;
            end
        endcase
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            if (win_oh[i]) begin
                sel_addr  = REQ_ADDR[32*i +: 32];
                sel_wdata = REQ_WDATA[16*i +: 16];
            end
        end
    end

    assign sel_wr    = |(win_oh & REQ_WRITE);
    assign can_grant = SD_HAS_INITIALIZED & ~SD_IS_READING & ~SD_IS_WRITING & (|REQ);
    assign busy_sel  = op_wr_q ? SD_IS_WRITING : SD_IS_READING;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        done_d     = 3'b000;
        err_d      = err_q;
        rdata_d    = rdata_q;
        to_read_d  = to_read_q;
        to_write_d = to_write_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        op_wr_d    = op_wr_q;
        last_d     = last_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (can_grant) begin
                    grant_d    = win_oh;
                    op_wr_d    = sel_wr;
                    to_read_d  = ~sel_wr;
                    to_write_d = sel_wr;
                    rd_addr_d  = sel_wr ? 32'd0 : sel_addr;
                    wr_addr_d  = sel_wr ? sel_addr : 32'd0;
                    wr_data_d  = sel_wr ? sel_wdata : 16'd0;
                    cnt_d      = '0;
                    state_d    = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (busy_sel) begin
                    to_read_d  = 1'b0;
                    to_write_d = 1'b0;
                    state_d    = ST_BUSY;
                end else if (cnt_q == TO_LAST) begin
                    // Controller never took the command: report it without a transfer.
                    to_read_d  = 1'b0;
                    to_write_d = 1'b0;
                    rd_addr_d  = '0;
                    wr_addr_d  = '0;
                    wr_data_d  = '0;
                    err_d      = 1'b1;
                    done_d     = grant_q;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            ST_BUSY: begin
                if (!busy_sel) begin
                    if (!op_wr_q) rdata_d = SD_READ_DATA;
                    rd_addr_d = '0;
                    wr_addr_d = '0;
                    wr_data_d = '0;
                    done_d    = grant_q;
                    state_d   = ST_DONE;
                end
            end

            default: begin
                grant_d = 3'b000;
                err_d   = 1'b0;
                case (grant_q)
                    3'b001:  last_d = 2'd0;
                    3'b010:  last_d = 2'd1;
                    default: last_d = 2'd2;
                endcase
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            grant_q    <= 3'b000;
            done_q     <= 3'b000;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            to_read_q  <= 1'b0;
            to_write_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            op_wr_q    <= 1'b0;
            last_q     <= 2'd2;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            to_read_q  <= to_read_d;
            to_write_q <= to_write_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            op_wr_q    <= op_wr_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
        end
    end

    assign GRANT            = grant_q;
    assign DONE             = done_q;
    assign ERR              = err_q;
    assign RDATA            = rdata_q;
    assign SD_TO_READ       = to_read_q;
    assign SD_TO_WRITE      = to_write_q;
    assign SD_READ_ADDRESS  = rd_addr_q;
    assign SD_WRITE_ADDRESS = wr_addr_q;
    assign SD_WRITE_DATA    = wr_data_q;

endmodule

// File: tb/tb_sd_access_arbiter.sv
// Bench for sd_access_arbiter: behavioural SD controller, vector table, corner sequences, random rounds.
module tb_sd_access_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [2:0]  REQ;
    logic [2:0]  REQ_WRITE;
    logic [95:0] REQ_ADDR;
    logic [47:0] REQ_WDATA;
    logic [2:0]  GRANT;
    logic [2:0]  DONE;
    logic        ERR;
    logic [15:0] RDATA;
    logic        SD_HAS_INITIALIZED;
    logic        SD_IS_READING;
    logic        SD_IS_WRITING;
    logic [15:0] SD_READ_DATA;
    logic        SD_TO_READ;
    logic        SD_TO_WRITE;
    logic [31:0] SD_READ_ADDRESS;
    logic [31:0] SD_WRITE_ADDRESS;
    logic [15:0] SD_WRITE_DATA;

    sd_access_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .GRANT(GRANT), .DONE(DONE),
        .ERR(ERR), .RDATA(RDATA), .SD_HAS_INITIALIZED(SD_HAS_INITIALIZED),
        .SD_IS_READING(SD_IS_READING), .SD_IS_WRITING(SD_IS_WRITING),
        .SD_READ_DATA(SD_READ_DATA), .SD_TO_READ(SD_TO_READ), .SD_TO_WRITE(SD_TO_WRITE),
        .SD_READ_ADDRESS(SD_READ_ADDRESS), .SD_WRITE_ADDRESS(SD_WRITE_ADDRESS),
        .SD_WRITE_DATA(SD_WRITE_DATA)
    );

    always #5 CLK = ~CLK;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] dflt(input logic [31:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    // ---------------- behavioural SD controller ----------------
    int          rise_dly = 1;
    int          busy_len = 1;
    bit          sd_mute = 0;
    logic [15:0] sd_mem [logic [31:0]];
    logic        cap_wr;
    logic [31:0] cap_addr;
    logic [15:0] cap_data;
    logic [31:0] lw_addr;
    logic [15:0] lw_data;

    initial begin
        SD_IS_READING = 1'b0;
        SD_IS_WRITING = 1'b0;
        SD_READ_DATA  = 16'h0;
        forever begin
            @(posedge CLK); #1;
            if (!sd_mute && !RESET && (SD_TO_READ || SD_TO_WRITE)) begin
                cap_wr   = SD_TO_WRITE;
                cap_addr = SD_TO_WRITE ? SD_WRITE_ADDRESS : SD_READ_ADDRESS;
                cap_data = SD_WRITE_DATA;
                if (rise_dly > 0) begin
                    repeat (rise_dly) @(posedge CLK);
                    #1;
                end
                if (cap_wr) begin
                    SD_IS_WRITING = 1'b1;
                    sd_mem[cap_addr] = cap_data;
                    lw_addr = cap_addr;
                    lw_data = cap_data;
                end else begin
                    SD_IS_READING = 1'b1;
                end
                repeat (busy_len) @(posedge CLK);
                #1;
                if (cap_wr) begin
                    SD_IS_WRITING = 1'b0;
                end else begin
                    SD_READ_DATA  = sd_mem.exists(cap_addr) ? sd_mem[cap_addr] : dflt(cap_addr);
                    SD_IS_READING = 1'b0;
                end
            end
        end
    end

    // ---------------- structural invariants ----------------
    int strobe_cnt = 0;
    int inv_viol = 0;

    always @(negedge CLK) begin
        if (!RESET) begin
            if (SD_TO_READ || SD_TO_WRITE) strobe_cnt++;
            if ($countones(GRANT) > 1) inv_viol++;
            if (SD_TO_READ && SD_TO_WRITE) inv_viol++;
            if ((SD_TO_READ || SD_TO_WRITE) && GRANT == 3'b000) inv_viol++;
            if ((DONE & ~GRANT) != 3'b000) inv_viol++;
        end
    end

    // ---------------- client helpers ----------------
    int          d_id[$];
    logic [15:0] d_rdata[$];
    logic        d_err[$];
    int          d_lat[$];

    task automatic set_client(input int c, input bit wr, input logic [31:0] a, input logic [15:0] d);
        REQ_WRITE[c]          = wr;
        REQ_ADDR[32*c +: 32]  = a;
        REQ_WDATA[16*c +: 16] = d;
    endtask

    task automatic run_group(input logic [2:0] mask);
        int cyc;
        logic [2:0] pend;
        d_id.delete(); d_rdata.delete(); d_err.delete(); d_lat.delete();
        @(negedge CLK);
        REQ = REQ | mask;
        strobe_cnt = 0;
        pend = mask;
        cyc = 0;
        while (pend != 3'b000 && cyc < 2000) begin
            @(negedge CLK);
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (DONE[i]) begin
                    d_id.push_back(i);
                    d_rdata.push_back(RDATA);
                    d_err.push_back(ERR);
                    d_lat.push_back(cyc);
                    pend[i] = 1'b0;
                    REQ[i] = 1'b0;
                end
            end
        end
        if (pend != 3'b000) begin
            check("group_timeout", 32'(pend), 32'h0);
            REQ = 3'b000;
        end
    endtask

    typedef struct {
        int          c;
        bit          wr;
        logic [31:0] addr;
        logic [15:0] wdata;
        int          rise;
        int          blen;
        bit          mute;
        bit          exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t        vt[8];
    int          exp_q[$];
    bit          rw[3];
    logic [31:0] ra[3];
    logic [15:0] rdv[3];
    logic [15:0] ref_mem [logic [31:0]];
    logic [15:0] ref_rdata;
    int          ref_ptr;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int cyc;
        int bad;
        int spurious;
        logic [2:0] mask;
        vec_t v;
        int c;

        vt[0] = '{1, 1'b0, 32'h0000_0200, 16'h0000, 3, 10, 1'b0, 1'b0, 16'hBEEF};
        vt[1] = '{0, 1'b1, 32'h0000_0400, 16'h7777, 2, 3,  1'b0, 1'b0, 16'hBEEF};
        vt[2] = '{2, 1'b0, 32'h0000_0400, 16'h0000, 1, 1,  1'b0, 1'b0, 16'h7777};
        vt[3] = '{0, 1'b0, 32'h0000_0800, 16'h0000, 1, 1,  1'b1, 1'b1, 16'h7777};
        vt[4] = '{1, 1'b1, 32'h0000_0200, 16'hCAFE, 4, 2,  1'b0, 1'b0, 16'h7777};
        vt[5] = '{0, 1'b0, 32'h0000_0200, 16'h0000, 1, 5,  1'b0, 1'b0, 16'hCAFE};
        vt[6] = '{2, 1'b0, 32'h0000_1000, 16'h0000, 2, 2,  1'b0, 1'b0, 16'h4A5A};
        vt[7] = '{1, 1'b1, 32'h0000_0040, 16'h9999, 0, 1,  1'b1, 1'b1, 16'h4A5A};
        sd_mem[32'h0000_0200] = 16'hBEEF;

        RESET = 1'b1;
        REQ = 3'b000; REQ_WRITE = 3'b000; REQ_ADDR = '0; REQ_WDATA = '0;
        SD_HAS_INITIALIZED = 1'b1;

        // Reset state; all three clients already requesting.
        set_client(0, 1'b1, 32'h10, 16'h1111);
        set_client(1, 1'b0, 32'h10, 16'h0);
        set_client(2, 1'b1, 32'h20, 16'h2222);
        repeat (3) @(negedge CLK);
        check("rst_grant", 32'(GRANT), 32'h0);
        check("rst_done", 32'(DONE), 32'h0);
        check("rst_err", 32'(ERR), 32'h0);
        check("rst_rdata", 32'(RDATA), 32'h0);
        check("rst_to_read", 32'(SD_TO_READ), 32'h0);
        check("rst_to_write", 32'(SD_TO_WRITE), 32'h0);
        check("rst_rd_addr", SD_READ_ADDRESS, 32'h0);
        check("rst_wr_addr", SD_WRITE_ADDRESS, 32'h0);
        check("rst_wr_data", 32'(SD_WRITE_DATA), 32'h0);
        RESET = 1'b0;

        // Contention: service order 0,1,2.
        rise_dly = 2; busy_len = 3;
        run_group(3'b111);
        check("cont_ndone", 32'(d_id.size()), 32'd3);
        if (d_id.size() == 3) begin
            check("cont_first", 32'(d_id[0]), 32'd0);
            check("cont_second", 32'(d_id[1]), 32'd1);
            check("cont_third", 32'(d_id[2]), 32'd2);
            check("cont_rdata", 32'(d_rdata[1]), 32'h1111);
        end

        // Round robin after client 1 served.
        set_client(1, 1'b0, 32'h20, 16'h0);
        run_group(3'b010);
        check("rr_single_rdata", 32'(d_rdata.size() > 0 ? d_rdata[0] : 16'hXXXX), 32'h2222);
        set_client(0, 1'b1, 32'h0000_0400, 16'h1234);
        set_client(1, 1'b0, 32'h0000_0400, 16'h0);
        run_group(3'b011);
        check("rr_ndone", 32'(d_id.size()), 32'd2);
        if (d_id.size() == 2) begin
            check("rr_first", 32'(d_id[0]), 32'd0);
            check("rr_second", 32'(d_id[1]), 32'd1);
            check("rr_readback", 32'(d_rdata[1]), 32'h1234);
        end
        check("rr_wr_addr", lw_addr, 32'h0000_0400);
        check("rr_wr_data", 32'(lw_data), 32'h1234);

        // Vector table: one client per record.
        for (int i = 0; i < 8; i++) begin
            v = vt[i];
            rise_dly = v.rise; busy_len = v.blen; sd_mute = v.mute;
            cap_wr = 1'bx; cap_addr = 'x; cap_data = 'x;
            set_client(v.c, v.wr, v.addr, v.wdata);
            run_group(3'b001 << v.c);
            sd_mute = 1'b0;
            check($sformatf("vec%0d_ndone", i), 32'(d_id.size()), 32'd1);
            if (d_id.size() == 1) begin
                check($sformatf("vec%0d_client", i), 32'(d_id[0]), 32'(v.c));
                check($sformatf("vec%0d_err", i), 32'(d_err[0]), 32'(v.exp_err));
                check($sformatf("vec%0d_rdata", i), 32'(d_rdata[0]), 32'(v.exp_rdata));
                check($sformatf("vec%0d_latency", i), 32'(d_lat[0]),
                      32'(v.mute ? 17 : v.rise + v.blen + 2));
            end
            check($sformatf("vec%0d_strobe_cycles", i), 32'(strobe_cnt),
                  32'(v.mute ? 16 : v.rise + 1));
            if (!v.mute) begin
                check($sformatf("vec%0d_sd_op", i), 32'(cap_wr), 32'(v.wr));
                check($sformatf("vec%0d_sd_addr", i), cap_addr, v.addr);
                check($sformatf("vec%0d_sd_wdata", i), 32'(cap_data), 32'(v.wr ? v.wdata : 16'h0));
            end
        end

        // Controller not initialized: no grant until it is.
        SD_HAS_INITIALIZED = 1'b0;
        rise_dly = 1; busy_len = 2;
        set_client(0, 1'b0, 32'h10, 16'h0);
        @(negedge CLK);
        REQ = 3'b001;
        bad = 0;
        repeat (50) begin
            @(negedge CLK);
            if (GRANT != 3'b000 || SD_TO_READ || SD_TO_WRITE) bad++;
        end
        check("noinit_idle", 32'(bad), 32'd0);
        SD_HAS_INITIALIZED = 1'b1;
        @(negedge CLK);
        check("noinit_grant", 32'(GRANT), 32'h1);
        cyc = 0;
        while (DONE[0] !== 1'b1 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
        check("noinit_done", 32'(DONE), 32'h1);
        check("noinit_rdata", 32'(RDATA), 32'h1111);
        REQ = 3'b000;

        // Reset while the controller is busy writing.
        rise_dly = 1; busy_len = 30;
        set_client(2, 1'b1, 32'h30, 16'h3333);
        @(negedge CLK);
        REQ = 3'b100;
        cyc = 0;
        while (!SD_IS_WRITING && cyc < 100) begin
            @(negedge CLK);
            cyc++;
        end
        check("rstb_busy_seen", 32'(SD_IS_WRITING), 32'h1);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        busy_len = 2;
        @(negedge CLK);
        check("rstb_grant", 32'(GRANT), 32'h0);
        check("rstb_to_write", 32'(SD_TO_WRITE), 32'h0);
        check("rstb_wr_addr", SD_WRITE_ADDRESS, 32'h0);
        check("rstb_wr_data", 32'(SD_WRITE_DATA), 32'h0);
        check("rstb_rdata", 32'(RDATA), 32'h0);
        RESET = 1'b0;
        bad = 0; spurious = 0; cyc = 0;
        while (SD_IS_WRITING && cyc < 100) begin
            @(negedge CLK);
            cyc++;
            if (GRANT != 3'b000) bad++;
            if (DONE != 3'b000) spurious++;
        end
        check("rstb_hold_grant", 32'(bad), 32'd0);
        check("rstb_no_done", 32'(spurious), 32'd0);
        @(negedge CLK);
        check("rstb_regrant", 32'(GRANT), 32'h4);
        cyc = 0;
        while (DONE[2] !== 1'b1 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
        check("rstb_done", 32'(DONE), 32'h4);
        REQ = 3'b000;

        // Random rounds against a transaction-level model.
        @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        ref_ptr = 2;
        ref_rdata = 16'h0;
        for (int r = 0; r < 40; r++) begin
            mask = 3'($urandom_range(1, 7));
            rise_dly = int'($urandom_range(0, 4));
            busy_len = int'($urandom_range(1, 6));
            for (int k = 0; k < 3; k++) begin
                if (mask[k]) begin
                    rw[k]  = 1'($urandom_range(0, 1));
                    ra[k]  = 32'h100 + 32'(4 * $urandom_range(0, 3));
                    rdv[k] = 16'($urandom);
                    set_client(k, rw[k], ra[k], rdv[k]);
                end
            end
            exp_q.delete();
            for (int j = 1; j <= 3; j++) begin
                c = (ref_ptr + j) % 3;
                if (mask[c]) exp_q.push_back(c);
            end
            run_group(mask);
            check($sformatf("rnd%0d_ndone", r), 32'(d_id.size()), 32'(exp_q.size()));
            for (int k = 0; k < exp_q.size() && k < d_id.size(); k++) begin
                c = exp_q[k];
                if (rw[c]) ref_mem[ra[c]] = rdv[c];
                else ref_rdata = ref_mem.exists(ra[c]) ? ref_mem[ra[c]] : dflt(ra[c]);
                check($sformatf("rnd%0d_order%0d", r, k), 32'(d_id[k]), 32'(c));
                check($sformatf("rnd%0d_err%0d", r, k), 32'(d_err[k]), 32'h0);
                check($sformatf("rnd%0d_rdata%0d", r, k), 32'(d_rdata[k]), 32'(ref_rdata));
            end
            if (exp_q.size() > 0) ref_ptr = exp_q[exp_q.size() - 1];
        end

        check("invariants", 32'(inv_viol), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
